tx_symbol_source: RTL

Parametrised symbol-rate timing and test-pattern source for the transmitter. It generates the oversampling phase counter and the symbol-rate strobe that drive the polyphase shaping filters. It also produces NCH parallel bit streams, one per channel (I, Q, ...), each from a per-channel-seeded PRBS or from one of several fixed test patterns. It sits at the head of the Tx chain, ahead of the per-channel filters, and adds run-enable, seed reload and pattern-mode selection to the basic counter and PRBS9 pair.

---
 rtl/tx_symbol_source.sv | 79 +++++++
 1 files changed

// File: rtl/tx_symbol_source.sv
// Symbol-rate timing and per-channel test-pattern source at the head of the Tx chain.
// Drives the polyphase index and symbol strobe, and supplies NCH PRBS or fixed-pattern bit streams.
module tx_symbol_source #(
    parameter int                          NCH        = 2,
    parameter int                          PRBS_ORDER = 9,
    parameter logic [NCH*PRBS_ORDER-1:0]   SEEDS      = {9'h1FE, 9'h1AA},
    parameter int                          OS         = 4
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_seed_load,
    input  logic [1:0]            i_mode,
    output logic [$clog2(OS)-1:0] o_phase,
    output logic                  o_sym_strobe,
    output logic [NCH-1:0]        o_bits
);

    localparam int PW  = $clog2(OS);
    localparam int TAP = (PRBS_ORDER == 7)  ? 6  :
                         (PRBS_ORDER == 15) ? 14 : 5;
    localparam logic [PW-1:0] LAST_PHASE = PW'(OS - 1);

    typedef enum logic [1:0] {
        MODE_PRBS  = 2'd0,
        MODE_ZEROS = 2'd1,
        MODE_ONES  = 2'd2,
        MODE_ALT   = 2'd3
    } mode_t;

    mode_t                               mode;
    logic [NCH-1:0][PRBS_ORDER-1:0]      sr;
    logic [NCH-1:0][PRBS_ORDER-1:0]      sr_next;
    logic [NCH-1:0]                      bits_next;
    logic                                alt;
    logic                                phase_last;

    assign mode       = mode_t'(i_mode);
    assign phase_last = (o_phase == LAST_PHASE);

    // Strobe is combinational so a same-cycle reload or reset suppresses it.
    assign o_sym_strobe = i_enable & ~i_reset & ~i_seed_load & phase_last;

    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        sr_next   = sr;
        bits_next = '0;
        for (int c = 0; c < NCH; c++) begin
            sr_next[c] = {sr[c][PRBS_ORDER-2:0], sr[c][PRBS_ORDER-1] ^ sr[c][TAP-1]};
            unique case (mode)
                MODE_PRBS:  bits_next[c] = sr[c][PRBS_ORDER-1];
                MODE_ZEROS: bits_next[c] = 1'b0;
                MODE_ONES:  bits_next[c] = 1'b1;
                MODE_ALT:   bits_next[c] = ~alt;
                default:    bits_next[c] = 1'b0;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (i_reset || i_seed_load) begin
            o_phase <= '0;
            o_bits  <= '0;
            alt     <= 1'b0;
            // NOTE: the LFSR bank must be reset to its seeds; an all-zero register would lock up.
            sr      <= SEEDS;
        end else if (i_enable) begin
            o_phase <= phase_last ? '0 : o_phase + PW'(1);
            // LFSRs advance in every mode so a return to PRBS resumes mid-sequence.
            if (phase_last) begin
                sr     <= sr_next;
                alt    <= ~alt;
                o_bits <= bits_next;
            end
        end
    end

endmodule
